// File: rtl/program_loader_pkg.sv
// Shared FSM state type and byte-stream format constants for the program loader.
package program_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DATA,
      ST_WRITE,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   localparam int COUNT_BYTES    = 4;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_BITS      = 8 * BYTES_PER_WORD;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/byte_assembler.sv
// Little-endian shift-in of stream bytes into a word, with a byte position counter.
// word_next exposes the word as it will be once the current byte is shifted in.
module byte_assembler
   import program_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 shift,
   input  logic [7:0]           byte_in,
   output logic [WORD_BITS-1:0] word,
   output logic [WORD_BITS-1:0] word_next,
   output logic                 last_byte
);

   logic [BYTE_IDX_W-1:0] byte_index;

   // Bytes enter at the top so the first byte ends up least significant.
   assign word_next = {byte_in, word[WORD_BITS-1:8]};
   assign last_byte = (byte_index == LAST_BYTE_IDX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word       <= '0;
         byte_index <= '0;
      end else if (clear) begin
         word       <= '0;
         byte_index <= '0;
      end else if (shift) begin
         word       <= word_next;
         byte_index <= byte_index + BYTE_IDX_W'(1);
      end
   end

endmodule

// File: rtl/program_loader.sv
// Loads a checksummed byte stream (count, little-endian words, XOR checksum) into
// instruction memory, holding the core in reset until a load completes cleanly.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int data_bits           = 32,
   parameter int memory_size         = 1024,
   parameter int memory_address_bits = $clog2(memory_size)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [7:0]                     byte_in,
   input  logic                           byte_valid,
   output logic                           byte_ready,
   output logic                           mem_write_enable,
   output logic [memory_address_bits-1:0] mem_address,
   output logic [data_bits-1:0]           mem_write_data,
   output logic                           core_hold,
   output logic                           done,
   output logic                           error
);

   // One extra bit so a count equal to memory_size is representable.
   localparam int IW = memory_address_bits + 1;

   loader_state_t        state, state_next;
   logic [IW-1:0]        word_index, word_count;
   logic [7:0]           checksum;
   logic [WORD_BITS-1:0] word, word_next;
   logic                 last_byte, accept, shift, load_start;

   assign accept = byte_valid & byte_ready;
   assign shift  = accept & ((state == ST_COUNT) | (state == ST_DATA));

   byte_assembler u_byte_assembler (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (load_start),
      .shift     (shift),
      .byte_in   (byte_in),
      .word      (word),
      .word_next (word_next),
      .last_byte (last_byte)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_index <= '0;
         word_count <= '0;
         checksum   <= '0;
      end else if (load_start) begin
         word_index <= '0;
         word_count <= '0;
         checksum   <= '0;
      end else begin
         if (shift) checksum <= checksum ^ byte_in;
         if ((state == ST_COUNT) && shift && last_byte) word_count <= word_next[IW-1:0];
         if (state == ST_WRITE) word_index <= word_index + IW'(1);
      end
   end

   always_comb begin
      state_next       = state;
      load_start       = 1'b0;
      byte_ready       = 1'b0;
      mem_write_enable = 1'b0;
      mem_address      = '0;
      mem_write_data   = '0;
      unique case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               load_start = 1'b1;
               state_next = ST_COUNT;
            end
         end
         ST_COUNT: begin
            byte_ready = 1'b1;
            if (accept && last_byte) begin
               if (word_next > WORD_BITS'(memory_size)) state_next = ST_ERROR;
               else if (word_next == '0)                state_next = ST_CHECK;
               else                                     state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            byte_ready = 1'b1;
            if (accept && last_byte) state_next = ST_WRITE;
         end
         ST_WRITE: begin
            mem_write_enable = 1'b1;
            mem_address      = word_index[memory_address_bits-1:0];
            mem_write_data   = data_bits'(word);
            if ((word_index + IW'(1)) == word_count) state_next = ST_CHECK;
            else                                     state_next = ST_DATA;
         end
         ST_CHECK: begin
            byte_ready = 1'b1;
            if (accept) state_next = (byte_in == checksum) ? ST_DONE : ST_ERROR;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign core_hold = (state != ST_DONE);
   assign done      = (state == ST_DONE);
   assign error     = (state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized loads against a stream-level model of expected writes and status.
module tb_program_loader;

   localparam int DATA_BITS = 32;
   localparam int MEM_SIZE  = 1024;
   localparam int AW        = $clog2(MEM_SIZE);

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 start = 1'b0;
   logic [7:0]           byte_in = 8'h00;
   logic                 byte_valid = 1'b0;
   logic                 byte_ready, mem_write_enable, core_hold, done, error;
   logic [AW-1:0]        mem_address;
   logic [DATA_BITS-1:0] mem_write_data;

   int vectors = 0;
   int miscompares = 0;

   logic [AW-1:0] wa_q[$];
   logic [31:0]   wd_q[$];
   logic [31:0]   words[$];

   always #5 clk = ~clk;

   program_loader #(
      .data_bits   (DATA_BITS),
      .memory_size (MEM_SIZE)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .byte_in          (byte_in),
      .byte_valid       (byte_valid),
      .byte_ready       (byte_ready),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .core_hold        (core_hold),
      .done             (done),
      .error            (error)
   );

   // Every write strobe seen is logged, so writes that should not happen are caught.
   always @(negedge clk) begin
      if (mem_write_enable === 1'b1) begin
         wa_q.push_back(mem_address);
         wd_q.push_back(mem_write_data);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, byte_ready, 0);
      chk({tag, "_wen"},   mem_write_enable, 0);
      chk({tag, "_addr"},  mem_address, 0);
      chk({tag, "_wdata"}, mem_write_data, 0);
      chk({tag, "_hold"},  core_hold, 1);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_error"}, error, 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge right after the handshake edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      repeat (gap) @(negedge clk);
      byte_in    = b;
      byte_valid = 1'b1;
      while (byte_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("byte_ready_timeout", 0, 1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   // Full load of count n using the words queue; start_at pulses start before that data byte.
   task automatic load(input logic [31:0] n, input int gap, input bit bad, input int start_at);
      logic [7:0] cs;
      cs = 8'h00;
      wa_q.delete();
      wd_q.delete();
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         send_byte(n[8*i +: 8], gap);
         cs ^= n[8*i +: 8];
      end
      if (n > MEM_SIZE) begin
         chk("count_err_error", error, 1);
         chk("count_err_hold", core_hold, 1);
         chk("count_err_ready", byte_ready, 0);
         @(negedge clk);
         chk("count_err_writes", wa_q.size(), 0);
         return;
      end
      for (int w = 0; w < int'(n); w++) begin
         for (int b = 0; b < 4; b++) begin
            if (w * 4 + b == start_at) begin
               pulse_start();
               chk("start_ignored_ready", byte_ready, 1);
               chk("start_ignored_error", error, 0);
            end
            send_byte(words[w][8*b +: 8], gap);
            cs ^= words[w][8*b +: 8];
            if (b == 3) begin
               chk("wr_en", mem_write_enable, 1);
               chk("wr_addr", mem_address, w);
               chk("wr_data", mem_write_data, words[w]);
               chk("wr_ready_low", byte_ready, 0);
            end
         end
      end
      send_byte(cs ^ {7'd0, bad}, gap);
      chk("end_done", done, !bad);
      chk("end_error", error, bad);
      chk("end_hold", core_hold, bad);
      @(negedge clk);
      chk("write_count", wa_q.size(), n);
      for (int w = 0; w < wa_q.size() && w < int'(n); w++) begin
         chk("log_addr", wa_q[w], w);
         chk("log_data", wd_q[w], words[w]);
      end
   endtask

   initial begin
      logic [31:0] rn;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      reset_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("idle");

      // Two-word program with correct checksum.
      words.delete();
      words.push_back(32'h0050_0093);
      words.push_back(32'h0010_0113);
      load(32'd2, 0, 1'b0, -1);

      // Empty program: good and bad checksum.
      load(32'd0, 0, 1'b0, -1);
      load(32'd0, 0, 1'b1, -1);

      // Count larger than memory.
      load(32'd1025, 0, 1'b0, -1);

      // Valid toggled every other cycle, three random words.
      words.delete();
      repeat (3) words.push_back($urandom);
      load(32'd3, 1, 1'b0, -1);

      // Start pulsed mid-DATA is ignored.
      words.delete();
      repeat (2) words.push_back($urandom);
      load(32'd2, 0, 1'b0, 2);

      // Count exactly memory_size is accepted into DATA, then reset aborts it.
      wa_q.delete();
      wd_q.delete();
      rn = MEM_SIZE;
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(rn[8*i +: 8], 0);
      chk("max_count_error", error, 0);
      chk("max_count_ready", byte_ready, 1);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("max_count_rst");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset dropped after the fifth data byte.
      words.delete();
      repeat (4) words.push_back($urandom);
      wa_q.delete();
      wd_q.delete();
      rn = 32'd4;
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(rn[8*i +: 8], 0);
      for (int k = 0; k < 5; k++) send_byte(words[k / 4][8*(k % 4) +: 8], 0);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("midload_rst");
      repeat (3) @(negedge clk);
      chk("midload_writes", wa_q.size(), 1);
      if (wd_q.size() > 0) chk("midload_wdata", wd_q[0], words[0]);
      reset_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midload_idle");

      // Randomized loads.
      repeat (6) begin
         int n;
         n = $urandom_range(1, 5);
         words.delete();
         repeat (n) words.push_back($urandom);
         load(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter data_bits, default 32, meaning instruction word width.
REQ-002 The block SHALL have parameter memory_size, default 1024, meaning instruction memory depth in words.
REQ-003 The block SHALL have parameter memory_address_bits, default $clog2(memory_size), meaning word address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: load request pulse.
REQ-007 The block SHALL have port byte_in, input, 8 bits: load stream byte.
REQ-008 The block SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-009 The block SHALL have port byte_ready, output, 1 bit: the block accepts byte_in this cycle.
REQ-010 The block SHALL have port mem_write_enable, output, 1 bit: instruction memory write strobe.
REQ-011 The block SHALL have port mem_address, output, memory_address_bits: word address of the write.
REQ-012 The block SHALL have port mem_write_data, output, data_bits: word to write.
REQ-013 The block SHALL have port core_hold, output, 1 bit: holds the core in reset while high.
REQ-014 The block SHALL have port done, output, 1 bit: load completed with a good checksum.
REQ-015 The block SHALL have port error, output, 1 bit: load aborted.

Function
REQ-016 A byte SHALL transfer only on a rising edge with byte_valid and byte_ready both high.
REQ-017 The stream format SHALL be: 4 count bytes (N words, little-endian), then 4*N data bytes (little-endian words), then 1 checksum byte.
REQ-018 The checksum SHALL be the XOR of all count bytes and all data bytes.
REQ-019 The FSM SHALL have the states IDLE, COUNT, DATA, WRITE, CHECK, DONE and ERROR.
REQ-020 In IDLE, DONE or ERROR, start high SHALL clear the word address, byte index and checksum and go to COUNT; start SHALL be ignored in all other states.
REQ-021 byte_ready SHALL be high only in COUNT, DATA and CHECK.
REQ-022 After the 4th count byte, N > memory_size SHALL go to ERROR, N = 0 SHALL go to CHECK, and any other N SHALL go to DATA.
REQ-023 In DATA, the 4th byte of a word SHALL move the FSM to WRITE.
REQ-024 WRITE SHALL last exactly one cycle with mem_write_enable = 1, mem_address = the word index and mem_write_data = the assembled word; byte_ready SHALL be 0 in WRITE.
REQ-025 The write SHALL occur on the cycle after the 4th byte handshake.
REQ-026 After the write, the word index SHALL increment; the FSM SHALL go to CHECK if the index equals N, else back to DATA.
REQ-027 The word index SHALL never wrap, because N <= memory_size is guaranteed by REQ-022.
REQ-028 In CHECK, an accepted byte equal to the running XOR SHALL go to DONE; otherwise it SHALL go to ERROR.
REQ-029 core_hold SHALL be 1 in every state except DONE.
REQ-030 done SHALL equal (state == DONE), and error SHALL equal (state == ERROR).
REQ-031 mem_write_enable SHALL be 0 outside WRITE.
REQ-032 Gaps in byte_valid SHALL only stall the FSM and SHALL NOT cause a timeout.

Reset
REQ-033 On reset_n low, the block SHALL asynchronously enter IDLE with byte_ready = 0, mem_write_enable = 0, mem_address = 0, mem_write_data = 0, core_hold = 1, done = 0 and error = 0, and with the checksum, byte index and word index cleared.
REQ-034 Reset asserted mid-load SHALL abort the load with no further writes; memory contents already written SHALL be left unchanged.

Structure
REQ-035 The state enum and the stream constants (COUNT_BYTES = 4, BYTES_PER_WORD = 4) SHALL live in a shared loader package.
REQ-036 One sub-module, byte_assembler (shift-in of bytes to a 32-bit little-endian word, plus a byte counter), SHALL be used.

Verification
REQ-037 The bench SHALL cover: start, count 2, words 0x00500093 and 0x00100113, correct checksum -> writes at address 0 then address 1 with those data, done = 1 and core_hold = 0.
REQ-038 The bench SHALL cover: count 0 followed by checksum 0x00 -> no write and done = 1; checksum 0x01 -> error = 1 and core_hold = 1.
REQ-039 The bench SHALL cover: count 1025 -> error immediately after the 4th count byte, with no write.
REQ-040 The bench SHALL cover: byte_valid toggled every other cycle with count 3 -> exactly 3 writes, each one cycle after its 4th byte, with byte_ready low during each write.
REQ-041 The bench SHALL cover: reset_n dropped after the 5th data byte -> IDLE, with mem_write_enable = 0 and core_hold = 1 at once.
REQ-042 The bench SHALL cover: start asserted during DATA -> ignored, and the load completes normally.
